lfsr_spawn: RTL and testbench
=============================

Name: lfsr_spawn

Overview:
- Parametrised Galois LFSR random source for the snake playfield.
- Adds enable, seed load and zero-lockup protection.
- Adds a food-spawn search engine: on request, it walks the LFSR sequence by rejection sampling until a candidate cell is in range and unoccupied, or until a try limit is hit.
- Sits between the game-control FSM (req/done) and the snake-body occupancy lookup (cand/cand_occ).

Parameters:
- W, 9, LFSR/state width in bits.
- TAPS, 9'h070, feedback mask: bit k=1 means new[k] also XORs in old[W-1], for k>=1; bit 0 ignored.
- SEED, 9'd132, reset value and substitute for any zero load.
- LIMIT, 300, number of valid cells; a candidate is accepted only if cand < LIMIT.
- MAX_TRIES, 64, maximum candidates evaluated per search.
- TW, $clog2(MAX_TRIES+1), try-counter width.

Ports:
- clk  in  1  system clock, all flops on rising edge
- rst  in  1  asynchronous active-high reset
- en  in  1  free-run step enable while idle
- load  in  1  load seed into LFSR
- seed  in  W  value for load
- rand_num  out  W  current LFSR state
- req  in  1  spawn request, sampled in IDLE only
- cand  out  W  candidate cell index, equal to rand_num
- cand_occ  in  1  combinational occupancy of cand, same cycle
- searching  out  1  high in SEARCH
- done  out  1  one-cycle pulse at search end
- fail  out  1  valid with done: 1 = try limit hit
- pos  out  W  accepted cell, held until next successful search

Behaviour:
- Reset, asynchronous on rst=1:
  - state=SEED, FSM=IDLE, try count=0.
  - searching=0, done=0, fail=0, pos=0.
- LFSR step function:
  - new[0]=old[W-1].
  - new[k]=old[k-1] ^ (TAPS[k] & old[W-1]) for 1<=k<W.
- LFSR update priority, highest first:
  - load=1: state <= (seed==0 ? SEED : seed).
  - Else step when (FSM==SEARCH) or (FSM==IDLE && en).
  - Else hold.
- Zero protection: the state can never become 0. Load of 0 substitutes SEED; a stepped value is never 0 for a nonzero state.
- FSM states IDLE, SEARCH, DONE:
  - IDLE: req=1 -> SEARCH, try count cleared to 0. Otherwise stay.
  - SEARCH, evaluated each cycle on the current cand:
    - accept = (cand < LIMIT) && !cand_occ.
    - If accept: pos <= cand, fail <= 0, go to DONE.
    - Else if try count == MAX_TRIES-1: fail <= 1, pos holds, go to DONE.
    - Else try count++, stay in SEARCH.
  - The LFSR steps every SEARCH cycle, including the accepting cycle.
  - DONE: done=1 for exactly this cycle, then go to IDLE.
- Output timing:
  - searching=1 exactly in SEARCH cycles.
  - done and fail are registered and update together.
  - fail holds its value until the next done.
- Latency: req in IDLE cycle N; first candidate evaluated in cycle N+1; an acceptance on the k-th candidate gives done in cycle N+1+k.
- Boundary conditions:
  - req in SEARCH or DONE is ignored and not queued.
  - load during SEARCH takes effect next cycle; the search continues on the new state and the try count is unaffected.
  - cand >= LIMIT is rejected regardless of cand_occ.
  - If LIMIT >= 2^W, the range check is always true.
  - rst mid-search aborts immediately to IDLE; no done pulse.
- Arithmetic: comparisons are unsigned. The try counter never exceeds MAX_TRIES-1.

Test Plan:
- Reset, then en=1 for 3 cycles -> rand_num sequence 132, 264, 97, 194. Then en=0 -> rand_num holds at 194.
- load=1 with seed=0 -> next cycle rand_num=132. load=1 with seed=5 while en=1 -> rand_num=5, since load wins over step.
- After reset, en=0, req pulse, cand_occ=0 -> searching for 1 cycle, done pulse with fail=0, pos=132.
- After reset, en=0, req pulse, cand_occ=1 when cand is 132 or 264 -> 3 SEARCH cycles, then done with fail=0, pos=97. rand_num=194 in the done cycle.
- MAX_TRIES=4, cand_occ tied 1, req -> exactly 4 SEARCH cycles, then done=1, fail=1, pos unchanged from previous value. A req asserted during SEARCH produces no second search.
- Assert rst during the 2nd SEARCH cycle -> immediate IDLE, searching=0, no done, rand_num=132. A following req runs a normal search.

Source files
------------

// File: rtl/lfsr_spawn.sv
// Galois LFSR random source with seed load and zero-lockup protection, plus a
// rejection-sampling food-spawn search engine for the snake playfield.
module lfsr_spawn #(
   parameter int             W         = 9,
   parameter logic [W-1:0]   TAPS      = 9'h070,
   parameter logic [W-1:0]   SEED      = 9'd132,
   parameter int             LIMIT     = 300,
   parameter int             MAX_TRIES = 64,
   parameter int             TW        = $clog2(MAX_TRIES + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         load,
   input  logic [W-1:0] seed,
   output logic [W-1:0] rand_num,
   input  logic         req,
   output logic [W-1:0] cand,
   input  logic         cand_occ,
   output logic         searching,
   output logic         done,
   output logic         fail,
   output logic [W-1:0] pos
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SEARCH = 2'd1,
      S_DONE   = 2'd2
   } state_e;

   // 32-bit unsigned bound so a LIMIT of 2^W or more makes the range check always pass.
   localparam logic [31:0] LIMIT_U = 32'(LIMIT);
   localparam logic [TW-1:0] LAST_TRY = TW'(MAX_TRIES - 1);

   state_e        state_q, state_d;
   logic [W-1:0]  lfsr_q, lfsr_d;
   logic [TW-1:0] tries_q, tries_d;
   logic          done_q, done_d;
   logic          fail_q, fail_d;
   logic [W-1:0]  pos_q, pos_d;
   logic          accept;

   function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] s);
      logic [W-1:0] n;
      n[0] = s[W-1];
      for (int k = 1; k < W; k++) begin
         n[k] = s[k-1] ^ (TAPS[k] & s[W-1]);
      end
      return n;
   endfunction

   assign accept = (32'(lfsr_q) < LIMIT_U) && !cand_occ;

   // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      tries_d = tries_q;
      done_d  = 1'b0;
      fail_d  = fail_q;
      pos_d   = pos_q;

      unique case (state_q)
         S_IDLE: begin
            if (req) begin
               state_d = S_SEARCH;
               tries_d = '0;
            end
         end
         S_SEARCH: begin
            if (accept) begin
               pos_d   = lfsr_q;
               fail_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_DONE;
            end else if (tries_q == LAST_TRY) begin
               fail_d  = 1'b1;
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               tries_d = tries_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Load beats stepping; a zero seed would lock the LFSR, so SEED replaces it.
      if (load) begin
         lfsr_d = (seed == '0) ? SEED : seed;
      end else if (state_q == S_SEARCH || (state_q == S_IDLE && en)) begin
         lfsr_d = lfsr_next(lfsr_q);
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         lfsr_q  <= SEED;
         tries_q <= '0;
         done_q  <= 1'b0;
         fail_q  <= 1'b0;
         pos_q   <= '0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         tries_q <= tries_d;
         done_q  <= done_d;
         fail_q  <= fail_d;
         pos_q   <= pos_d;
      end
   end

   assign rand_num  = lfsr_q;
   assign cand      = lfsr_q;
   assign searching = (state_q == S_SEARCH);
   assign done      = done_q;
   assign fail      = fail_q;
   assign pos       = pos_q;

endmodule

// File: tb/tb_lfsr_spawn.sv
// Self-checking bench for lfsr_spawn: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_lfsr_spawn;

   localparam int W     = 9;
   localparam int TAPS  = 'h070;
   localparam int SEED  = 132;
   localparam int LIMIT = 300;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en = 1'b0, load = 1'b0, req = 1'b0;
   logic [W-1:0] seed = '0;
   logic         cand_occ0, cand_occ4;

   logic [W-1:0] rand_num0, cand0, pos0, rand_num4, cand4, pos4;
   logic         searching0, done0, fail0, searching4, done4, fail4;

   int n_tests = 0;
   int n_fail  = 0;
   bit cmp_en  = 1'b0;
   int occ_mode = 0;
   bit occ_map [512];

   always #5 clk = ~clk;

   lfsr_spawn dut (
      .clk(clk), .rst(rst), .en(en), .load(load), .seed(seed),
      .rand_num(rand_num0), .req(req), .cand(cand0), .cand_occ(cand_occ0),
      .searching(searching0), .done(done0), .fail(fail0), .pos(pos0)
   );

   lfsr_spawn #(.MAX_TRIES(4)) dut4 (
      .clk(clk), .rst(rst), .en(en), .load(load), .seed(seed),
      .rand_num(rand_num4), .req(req), .cand(cand4), .cand_occ(cand_occ4),
      .searching(searching4), .done(done4), .fail(fail4), .pos(pos4)
   );

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // phase: 0 = idle, 1 = searching, 2 = done-pulse cycle
   typedef struct {
      int st;
      int phase;
      int tries;
      int fail;
      int pos;
   } mdl_t;

   localparam mdl_t MDL_RST = '{st: SEED, phase: 0, tries: 0, fail: 0, pos: 0};

   mdl_t m0 = MDL_RST;
   mdl_t m4 = MDL_RST;

   // Multiply by x modulo the feedback polynomial: shift left, fold the overflow bit back.
   function automatic int lfsr_ref(input int x);
      int v;
      v = x << 1;
      if (v >= (1 << W)) v = (v - (1 << W)) ^ 1 ^ (TAPS & 'h1FE);
      return v;
   endfunction

   function automatic mdl_t mstep(input mdl_t m, input bit occ, input int max_tries,
                                  input bit i_en, input bit i_load, input bit i_req,
                                  input int i_seed);
      mdl_t n;
      n = m;
      if (m.phase == 0) begin
         if (i_req) begin
            n.phase = 1;
            n.tries = 0;
         end
      end else if (m.phase == 1) begin
         if (m.st < LIMIT && !occ) begin
            n.pos = m.st; n.fail = 0; n.phase = 2;
         end else if (m.tries + 1 >= max_tries) begin
            n.fail = 1; n.phase = 2;
         end else begin
            n.tries = m.tries + 1;
         end
      end else begin
         n.phase = 0;
      end
      if (i_load)
         n.st = (i_seed == 0) ? SEED : i_seed;
      else if (m.phase == 1 || (m.phase == 0 && i_en))
         n.st = lfsr_ref(m.st);
      return n;
   endfunction

   assign cand_occ0 = (occ_mode == 0) ? 1'b0 : (occ_mode == 1) ? 1'b1 :
                      (occ_mode == 2) ? (m0.st == 132 || m0.st == 264) : occ_map[m0.st];
   assign cand_occ4 = (occ_mode == 0) ? 1'b0 : (occ_mode == 1) ? 1'b1 :
                      (occ_mode == 2) ? (m4.st == 132 || m4.st == 264) : occ_map[m4.st];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m0 <= MDL_RST;
         m4 <= MDL_RST;
      end else begin
         m0 <= mstep(m0, cand_occ0, 64, en, load, req, int'(seed));
         m4 <= mstep(m4, cand_occ4, 4, en, load, req, int'(seed));
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("rand_num", int'(rand_num0), m0.st);
         check("cand", int'(cand0), m0.st);
         check("searching", int'(searching0), int'(m0.phase == 1));
         check("done", int'(done0), int'(m0.phase == 2));
         check("fail", int'(fail0), m0.fail);
         check("pos", int'(pos0), m0.pos);
         check("rand_num4", int'(rand_num4), m4.st);
         check("searching4", int'(searching4), int'(m4.phase == 1));
         check("done4", int'(done4), int'(m4.phase == 2));
         check("fail4", int'(fail4), m4.fail);
         check("pos4", int'(pos4), m4.pos);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int n0, n4, got_done4;

      // Reset values and free-run sequence.
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      cmp_en = 1'b1;
      check("rst_rand", int'(rand_num0), 132);
      check("rst_search", int'(searching0), 0);
      check("rst_done", int'(done0), 0);
      check("rst_fail", int'(fail0), 0);
      check("rst_pos", int'(pos0), 0);
      en = 1'b1;
      tick(); check("step1", int'(rand_num0), 264);
      tick(); check("step2", int'(rand_num0), 97);
      tick(); check("step3", int'(rand_num0), 194);
      en = 1'b0;
      tick(); check("hold", int'(rand_num0), 194);

      // Zero load substitutes SEED; load wins over step.
      load = 1'b1; seed = '0;
      tick(); check("load0", int'(rand_num0), 132);
      seed = 9'd5; en = 1'b1;
      tick(); check("load5", int'(rand_num0), 5);
      load = 1'b0; en = 1'b0; seed = '0;

      // First candidate accepted.
      reset_pulse();
      occ_mode = 0;
      req = 1'b1;
      tick(); req = 1'b0;
      check("s1_searching", int'(searching0), 1);
      tick();
      check("s1_done", int'(done0), 1);
      check("s1_fail", int'(fail0), 0);
      check("s1_pos", int'(pos0), 132);
      tick();
      check("s1_done_off", int'(done0), 0);

      // 132 and 264 occupied -> accepts 97 on the third candidate.
      reset_pulse();
      occ_mode = 2;
      req = 1'b1;
      tick(); req = 1'b0;
      n0 = 0;
      while (searching0 && n0 < 20) begin n0++; tick(); end
      check("s2_cycles", n0, 3);
      check("s2_done", int'(done0), 1);
      check("s2_fail", int'(fail0), 0);
      check("s2_pos", int'(pos0), 97);
      check("s2_rand", int'(rand_num0), 194);
      tick();

      // Everything occupied: dut4 gives up after 4 tries, dut after 64; req during SEARCH is ignored.
      occ_mode = 1;
      req = 1'b1;
      tick();
      n0 = 0; n4 = 0; got_done4 = 0;
      for (int i = 0; i < 100; i++) begin
         if (!searching0 && !searching4) break;
         if (searching0) n0++;
         if (searching4) n4++;
         if (done4) begin
            got_done4++;
            check("s3_fail4", int'(fail4), 1);
            check("s3_pos4", int'(pos4), 97);
         end
         if (i == 1) req = 1'b0;
         tick();
      end
      req = 1'b0;
      check("s3_tries4", n4, 4);
      check("s3_done4_once", got_done4, 1);
      check("s3_tries", n0, 64);
      check("s3_done", int'(done0), 1);
      check("s3_fail", int'(fail0), 1);
      check("s3_pos", int'(pos0), 97);
      check("s3_no_respawn4", int'(searching4), 0);
      tick();

      // Reset during the second SEARCH cycle.
      reset_pulse();
      occ_mode = 1;
      req = 1'b1;
      tick(); req = 1'b0;
      tick();
      check("s4_in_search", int'(searching0), 1);
      rst = 1'b1;
      #1;
      check("s4_abort_search", int'(searching0), 0);
      check("s4_abort_done", int'(done0), 0);
      check("s4_abort_rand", int'(rand_num0), 132);
      tick(); rst = 1'b0;
      tick();
      check("s4_no_done", int'(done0), 0);
      occ_mode = 0;
      req = 1'b1;
      tick(); req = 1'b0;
      tick();
      check("s4_next_done", int'(done0), 1);
      check("s4_next_fail", int'(fail0), 0);
      check("s4_next_pos", int'(pos0), 132);

      // Randomized traffic against the model.
      for (int c = 0; c < 512; c++) occ_map[c] = ($urandom_range(0, 99) < 60);
      occ_mode = 3;
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500)
            for (int c = 0; c < 512; c++) occ_map[c] = ($urandom_range(0, 99) < 85);
         rst  = ($urandom_range(0, 299) == 0);
         en   = $urandom_range(0, 1);
         load = ($urandom_range(0, 15) == 0);
         seed = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
         req  = ($urandom_range(0, 3) == 0);
         tick();
      end
      rst = 1'b0; load = 1'b0; req = 1'b0; en = 1'b0;
      tick();
      @(negedge clk);
      #1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
